// File: rtl/mips32_pipe_il.sv
// Five-stage MIPS32 pipeline with forwarding, load-use interlock and branch flush.
// Define MIPS_PERF_CNT_EN to add the stall_cnt / flush_cnt performance counters.
module mips32_pipe_il #(
   parameter int MEM_AW   = 10,
   parameter int RESET_PC = 0,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              halted,
   output logic [MEM_AW-1:0] pc,
`ifdef MIPS_PERF_CNT_EN
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
`endif
   output logic [CNT_W-1:0]  instret
);

   localparam logic [5:0] OP_ADD   = 6'h00;
   localparam logic [5:0] OP_SUB   = 6'h01;
   localparam logic [5:0] OP_AND   = 6'h02;
   localparam logic [5:0] OP_OR    = 6'h03;
   localparam logic [5:0] OP_SLT   = 6'h04;
   localparam logic [5:0] OP_MUL   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h08;
   localparam logic [5:0] OP_SW    = 6'h09;
   localparam logic [5:0] OP_ADDI  = 6'h0A;
   localparam logic [5:0] OP_SUBI  = 6'h0B;
   localparam logic [5:0] OP_SLTI  = 6'h0C;
   localparam logic [5:0] OP_BNEQZ = 6'h0D;
   localparam logic [5:0] OP_BEQZ  = 6'h0E;
   localparam logic [5:0] OP_HLT   = 6'h3F;

   logic [31:0] Reg [0:31];
   logic [31:0] Mem [0:2**MEM_AW-1];

   function automatic logic is_rtype(input logic [5:0] op);
      return op <= OP_MUL;
   endfunction

   function automatic logic writes_rt(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_SLTI);
   endfunction

   function automatic logic reads_rs(input logic [5:0] op);
      return is_rtype(op) || ((op >= OP_LW) && (op <= OP_BEQZ));
   endfunction

   function automatic logic reads_rt(input logic [5:0] op);
      return is_rtype(op) || (op == OP_SW) || (op == OP_BNEQZ) || (op == OP_BEQZ);
   endfunction

   logic              halted_q, halted_d;
   logic              stop_q, stop_d;
   logic [MEM_AW-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  instret_q, instret_d;

   logic              ifid_valid_q, ifid_valid_d;
   logic [31:0]       ifid_ir_q, ifid_ir_d;
   logic [MEM_AW-1:0] ifid_pc_q, ifid_pc_d;

   logic              idex_valid_q, idex_valid_d;
   logic [31:0]       idex_ir_q, idex_ir_d;
   logic [MEM_AW-1:0] idex_pc_q, idex_pc_d;
   logic [31:0]       idex_a_q, idex_a_d;
   logic [31:0]       idex_b_q, idex_b_d;

   logic              exmem_valid_q, exmem_valid_d;
   logic              exmem_wr_q, exmem_wr_d;
   logic [4:0]        exmem_dst_q, exmem_dst_d;
   logic [31:0]       exmem_alu_q, exmem_alu_d;
   logic [31:0]       exmem_sd_q, exmem_sd_d;
   logic              exmem_load_q, exmem_load_d;
   logic              exmem_store_q, exmem_store_d;
   logic              exmem_hlt_q, exmem_hlt_d;

   logic              memwb_valid_q, memwb_valid_d;
   logic              memwb_wr_q, memwb_wr_d;
   logic [4:0]        memwb_dst_q, memwb_dst_d;
   logic [31:0]       memwb_result_q, memwb_result_d;
   logic              memwb_hlt_q, memwb_hlt_d;

`ifdef MIPS_PERF_CNT_EN
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
`endif

   logic [31:0]       fetch_ir;
   logic [5:0]        id_op;
   logic [4:0]        id_rs, id_rt;
   logic [31:0]       id_a, id_b;
   logic              id_hlt;
   logic              wb_we;

   logic [5:0]        ex_op;
   logic [4:0]        ex_rs, ex_rt, ex_rd, ex_dst;
   logic [31:0]       ex_imm, ex_a, ex_b, ex_alu;
   logic              ex_wr, ex_taken;
   logic [MEM_AW-1:0] ex_target;

   logic              load_use;
   logic [31:0]       mem_result;

   assign fetch_ir = Mem[pc_q];

   assign wb_we  = memwb_valid_q && memwb_wr_q && !halted_q;
   assign id_op  = ifid_ir_q[31:26];
   assign id_rs  = ifid_ir_q[25:21];
   assign id_rt  = ifid_ir_q[20:16];
   assign id_hlt = ifid_valid_q && (id_op == OP_HLT);

   // Register read with write-through of the instruction retiring this cycle.
   always_comb begin
      id_a = Reg[id_rs];
      id_b = Reg[id_rt];
      if (wb_we && (memwb_dst_q == id_rs)) id_a = memwb_result_q;
      if (wb_we && (memwb_dst_q == id_rt)) id_b = memwb_result_q;
      if (id_rs == 5'd0) id_a = '0;
      if (id_rt == 5'd0) id_b = '0;
   end

   assign ex_op  = idex_ir_q[31:26];
   assign ex_rs  = idex_ir_q[25:21];
   assign ex_rt  = idex_ir_q[20:16];
   assign ex_rd  = idex_ir_q[15:11];
   assign ex_imm = {{16{idex_ir_q[15]}}, idex_ir_q[15:0]};

   // Later assignments win, so EX/MEM beats MEM/WB beats the ID/EX copy.
   always_comb begin
      ex_a = idex_a_q;
      ex_b = idex_b_q;
      if (memwb_wr_q && (memwb_dst_q == ex_rs)) ex_a = memwb_result_q;
      if (memwb_wr_q && (memwb_dst_q == ex_rt)) ex_b = memwb_result_q;
      if (exmem_wr_q && !exmem_load_q && (exmem_dst_q == ex_rs)) ex_a = exmem_alu_q;
      if (exmem_wr_q && !exmem_load_q && (exmem_dst_q == ex_rt)) ex_b = exmem_alu_q;
   end

   always_comb begin
      ex_alu = '0;
      case (ex_op)
         OP_ADD:                 ex_alu = ex_a + ex_b;
         OP_SUB:                 ex_alu = ex_a - ex_b;
         OP_AND:                 ex_alu = ex_a & ex_b;
         OP_OR:                  ex_alu = ex_a | ex_b;
         OP_SLT:                 ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
         OP_MUL:                 ex_alu = ex_a * ex_b;
         OP_LW, OP_SW, OP_ADDI:  ex_alu = ex_a + ex_imm;
         OP_SUBI:                ex_alu = ex_a - ex_imm;
         OP_SLTI:                ex_alu = {31'd0, $signed(ex_a) < $signed(ex_imm)};
         default:                ex_alu = '0;
      endcase
   end

   assign ex_dst    = is_rtype(ex_op) ? ex_rd : ex_rt;
   assign ex_wr     = idex_valid_q && (is_rtype(ex_op) || writes_rt(ex_op)) && (ex_dst != 5'd0);
   assign ex_taken  = idex_valid_q && (((ex_op == OP_BNEQZ) && (ex_a != 32'd0)) ||
                                       ((ex_op == OP_BEQZ)  && (ex_a == 32'd0)));
   assign ex_target = idex_pc_q + MEM_AW'(1) + ex_imm[MEM_AW-1:0];

   assign load_use = idex_valid_q && (ex_op == OP_LW) && (ex_rt != 5'd0) && ifid_valid_q &&
                     ((reads_rs(id_op) && (id_rs == ex_rt)) ||
                      (reads_rt(id_op) && (id_rt == ex_rt)));

   assign mem_result = exmem_load_q ? Mem[exmem_alu_q[MEM_AW-1:0]] : exmem_alu_q;

   // Taken branch outranks the interlock, which outranks the HLT fetch stop.
   always_comb begin
      halted_d       = halted_q;
      stop_d         = stop_q;
      pc_d           = pc_q;
      instret_d      = instret_q;
      ifid_valid_d   = ifid_valid_q;
      ifid_ir_d      = ifid_ir_q;
      ifid_pc_d      = ifid_pc_q;
      idex_valid_d   = idex_valid_q;
      idex_ir_d      = idex_ir_q;
      idex_pc_d      = idex_pc_q;
      idex_a_d       = idex_a_q;
      idex_b_d       = idex_b_q;
      exmem_valid_d  = exmem_valid_q;
      exmem_wr_d     = exmem_wr_q;
      exmem_dst_d    = exmem_dst_q;
      exmem_alu_d    = exmem_alu_q;
      exmem_sd_d     = exmem_sd_q;
      exmem_load_d   = exmem_load_q;
      exmem_store_d  = exmem_store_q;
      exmem_hlt_d    = exmem_hlt_q;
      memwb_valid_d  = memwb_valid_q;
      memwb_wr_d     = memwb_wr_q;
      memwb_dst_d    = memwb_dst_q;
      memwb_result_d = memwb_result_q;
      memwb_hlt_d    = memwb_hlt_q;
`ifdef MIPS_PERF_CNT_EN
      stall_cnt_d    = stall_cnt_q;
      flush_cnt_d    = flush_cnt_q;
`endif
      if (!halted_q) begin
         if (memwb_valid_q) instret_d = instret_q + CNT_W'(1);
         if (memwb_valid_q && memwb_hlt_q) halted_d = 1'b1;

         memwb_valid_d  = exmem_valid_q;
         memwb_wr_d     = exmem_wr_q;
         memwb_dst_d    = exmem_dst_q;
         memwb_result_d = mem_result;
         memwb_hlt_d    = exmem_hlt_q;

         exmem_valid_d  = idex_valid_q;
         exmem_wr_d     = ex_wr;
         exmem_dst_d    = ex_dst;
         exmem_alu_d    = ex_alu;
         exmem_sd_d     = ex_b;
         exmem_load_d   = idex_valid_q && (ex_op == OP_LW);
         exmem_store_d  = idex_valid_q && (ex_op == OP_SW);
         exmem_hlt_d    = idex_valid_q && (ex_op == OP_HLT);

         if (ex_taken) begin
            pc_d         = ex_target;
            ifid_valid_d = 1'b0;
            idex_valid_d = 1'b0;
`ifdef MIPS_PERF_CNT_EN
            flush_cnt_d  = flush_cnt_q + CNT_W'(1);
`endif
         end else if (load_use) begin
            idex_valid_d = 1'b0;
`ifdef MIPS_PERF_CNT_EN
            stall_cnt_d  = stall_cnt_q + CNT_W'(1);
`endif
         end else begin
            idex_valid_d = ifid_valid_q;
            idex_ir_d    = ifid_ir_q;
            idex_pc_d    = ifid_pc_q;
            idex_a_d     = id_a;
            idex_b_d     = id_b;
            if (id_hlt || stop_q) begin
               ifid_valid_d = 1'b0;
               stop_d       = 1'b1;
            end else begin
               ifid_valid_d = 1'b1;
               ifid_ir_d    = fetch_ir;
               ifid_pc_d    = pc_q;
               pc_d         = pc_q + MEM_AW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted_q       <= 1'b0;
         stop_q         <= 1'b0;
         pc_q           <= MEM_AW'(RESET_PC);
         instret_q      <= '0;
         ifid_valid_q   <= 1'b0;
         ifid_ir_q      <= '0;
         ifid_pc_q      <= '0;
         idex_valid_q   <= 1'b0;
         idex_ir_q      <= '0;
         idex_pc_q      <= '0;
         idex_a_q       <= '0;
         idex_b_q       <= '0;
         exmem_valid_q  <= 1'b0;
         exmem_wr_q     <= 1'b0;
         exmem_dst_q    <= '0;
         exmem_alu_q    <= '0;
         exmem_sd_q     <= '0;
         exmem_load_q   <= 1'b0;
         exmem_store_q  <= 1'b0;
         exmem_hlt_q    <= 1'b0;
         memwb_valid_q  <= 1'b0;
         memwb_wr_q     <= 1'b0;
         memwb_dst_q    <= '0;
         memwb_result_q <= '0;
         memwb_hlt_q    <= 1'b0;
`ifdef MIPS_PERF_CNT_EN
         stall_cnt_q    <= '0;
         flush_cnt_q    <= '0;
`endif
      end else begin
         halted_q       <= halted_d;
         stop_q         <= stop_d;
         pc_q           <= pc_d;
         instret_q      <= instret_d;
         ifid_valid_q   <= ifid_valid_d;
         ifid_ir_q      <= ifid_ir_d;
         ifid_pc_q      <= ifid_pc_d;
         idex_valid_q   <= idex_valid_d;
         idex_ir_q      <= idex_ir_d;
         idex_pc_q      <= idex_pc_d;
         idex_a_q       <= idex_a_d;
         idex_b_q       <= idex_b_d;
         exmem_valid_q  <= exmem_valid_d;
         exmem_wr_q     <= exmem_wr_d;
         exmem_dst_q    <= exmem_dst_d;
         exmem_alu_q    <= exmem_alu_d;
         exmem_sd_q     <= exmem_sd_d;
         exmem_load_q   <= exmem_load_d;
         exmem_store_q  <= exmem_store_d;
         exmem_hlt_q    <= exmem_hlt_d;
         memwb_valid_q  <= memwb_valid_d;
         memwb_wr_q     <= memwb_wr_d;
         memwb_dst_q    <= memwb_dst_d;
         memwb_result_q <= memwb_result_d;
         memwb_hlt_q    <= memwb_hlt_d;
`ifdef MIPS_PERF_CNT_EN
         stall_cnt_q    <= stall_cnt_d;
         flush_cnt_q    <= flush_cnt_d;
`endif
      end
   end

   // Storage arrays are never reset so preloaded program/data survive a restart.
   always_ff @(posedge clk) begin
      if (wb_we) Reg[memwb_dst_q] <= memwb_result_q;
      if (exmem_valid_q && exmem_store_q && !halted_q)
         Mem[exmem_alu_q[MEM_AW-1:0]] <= exmem_sd_q;
   end

   assign halted  = halted_q;
   assign pc      = pc_q;
   assign instret = instret_q;
`ifdef MIPS_PERF_CNT_EN
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule
